sid_pot: RTL and testbench

Paddle/POT sampling engine for one SID instance: runs the 512-cycle discharge/charge measurement period and drives the external discharge switch. It counts charge time for the two POT channels and publishes the results as `sid::pot_reg_t` for the register read mux, which presents them at addresses 0x19/0x1A. It sits between the POT pad interface (`sid::pot_i_t` / `sid::pot_o_t`) and the bus read path, and advances once per SID (phi2) cycle.

---
 rtl/sid_pot.sv | 98 +++++++++
 tb/tb_sid_pot.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sid_pot.sv
// SID paddle/POT sampling engine: 512-tick discharge/charge measurement period
// with per-channel charge-time counters, published once per period.

package sid;
  typedef logic [8:0] reg9_t;

  typedef struct packed {
    logic [1:0] charged;   // bit 0 = X, bit 1 = Y
  } pot_i_t;

  typedef struct packed {
    logic discharge;       // 1 = capacitors shorted
  } pot_o_t;

  typedef struct packed {
    logic [1:0][7:0] xy;   // xy[0] = POTX, xy[1] = POTY
  } pot_reg_t;
endpackage

module sid_pot (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  sid::pot_i_t   pot_i,
  output sid::pot_o_t   pot_o,
  output sid::pot_reg_t pot,
  output logic          updated
);

  logic [1:0]      chg_meta;
  logic [1:0]      chg_s;
  sid::reg9_t      pos;
  sid::reg9_t      pos_nxt;
  logic [1:0][7:0] cnt;
  logic [1:0][7:0] cnt_nxt;
  logic [1:0]      done;
  logic [1:0]      done_nxt;
  logic            charge_phase;
  logic            last_pos;

  assign charge_phase = pos[8];
  assign last_pos     = (pos == 9'd511);
  assign pos_nxt      = pos + 9'd1;

  // The comparators are asynchronous to clk, so they are synchronised on
  // every clk rather than only on tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      chg_meta <= 2'b00;
      chg_s    <= 2'b00;
    end else begin
      chg_meta <= pot_i.charged;
      chg_s    <= chg_meta;
    end
  end

  // Per-channel counter update for the current tick. done latches the first
  // observed charge so a later comparator drop cannot resume counting.
  always_comb begin
    cnt_nxt  = cnt;
    done_nxt = done;
    for (int i = 0; i < 2; i++) begin
      if (!charge_phase) begin
        cnt_nxt[i]  = 8'd0;
        done_nxt[i] = 1'b0;
      end else if (chg_s[i]) begin
        done_nxt[i] = 1'b1;
      end else if (!done[i] && (cnt[i] != 8'hff)) begin
        cnt_nxt[i] = cnt[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos             <= '0;
      cnt             <= '0;
      done            <= 2'b00;
      pot_o.discharge <= 1'b1;
      pot.xy          <= '0;
      updated         <= 1'b0;
    end else begin
      updated <= 1'b0;
      if (tick) begin
        pos             <= pos_nxt;
        cnt             <= cnt_nxt;
        done            <= done_nxt;
        // Discharge is asserted for the whole lower half of the next period.
        pot_o.discharge <= ~pos_nxt[8];
        if (last_pos) begin
          pot.xy  <= cnt_nxt;
          updated <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sid_pot.sv
// Bench for sid_pot: randomized and directed measurement periods checked
// against a per-period "first tick seen charged" reference model.

module tb_sid_pot;
  localparam int NEVER = 100000;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  sid::pot_i_t   pot_i;
  sid::pot_o_t   pot_o;
  sid::pot_reg_t pot;
  logic          updated;

  always #5 clk = ~clk;

  sid_pot dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .pot_i   (pot_i),
    .pot_o   (pot_o),
    .pot     (pot),
    .updated (updated)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the tick-counted period position and, per channel,
  // the first charge-phase tick at which the comparator (2 clk late) is seen.
  int          mpos;
  int          first [2];
  logic [1:0]  h1, h2;
  logic        exp_disc;
  logic        exp_upd;
  logic [15:0] exp_xy;
  bit          model_ok = 1'b0;

  always @(posedge clk) begin : model
    logic [1:0] seen;
    int rd [2];
    seen = h2;
    h2 = h1;
    h1 = pot_i.charged;
    exp_upd = 1'b0;
    if (rst) begin
      model_ok = 1'b1;
      mpos = 0;
      first = '{-1, -1};
      h1 = 2'b00;
      h2 = 2'b00;
      exp_disc = 1'b1;
      exp_xy = 16'd0;
    end else if (tick && model_ok) begin
      if (mpos >= 256) begin
        for (int i = 0; i < 2; i++)
          if (first[i] < 0 && seen[i]) first[i] = mpos - 256;
      end
      if (mpos == 511) begin
        for (int i = 0; i < 2; i++) rd[i] = (first[i] < 0) ? 255 : first[i];
        exp_xy = {8'(rd[1]), 8'(rd[0])};
        exp_q.push_back(exp_xy);
        exp_upd = 1'b1;
        first = '{-1, -1};
      end
      mpos = (mpos + 1) % 512;
      exp_disc = (mpos < 256);
    end
  end

  // Monitor: compares on the falling edge, popping the scoreboard on updated.
  always @(negedge clk) begin
    if (model_ok) begin
      check("discharge", 16'(pot_o.discharge), 16'(exp_disc));
      check("updated", 16'(updated), 16'(exp_upd));
      check("pot_hold", pot, exp_xy);
      if (updated) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pot_pop: got update 0x%h expected no update", pot);
        end else begin
          check("pot_pop", pot, exp_q.pop_front());
        end
      end
    end
  end

  task automatic apply_reset(input int n);
    rst  = 1'b1;
    tick = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
    rst  = 1'b0;
    tick = 1'b0;
  endtask

  // One period (or its first nticks ticks) with a tick every s clk. Channel i
  // is driven so that it is first seen at pos 256+k_i; drop0 releases X early.
  task automatic run_period(input int s, input int kx, input int ky,
                            input int drop0, input int nticks);
    int tx, ty;
    tx = (256 + kx) * s;
    ty = (256 + ky) * s;
    for (int c = 0; c < nticks * s; c++) begin
      tick = (c % s == 0);
      pot_i.charged[0] = (c >= tx - 2) && (c < drop0 * s);
      pot_i.charged[1] = (c >= ty - 2);
      @(posedge clk);
      #2;
    end
    tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick = 1'b1;
    pot_i = '0;
    apply_reset(3);
    check("reset_xy", pot, 16'd0);
    check("reset_disc", 16'(pot_o.discharge), 16'd1);
    check("reset_upd", 16'(updated), 16'd0);

    run_period(1, 999, 999, NEVER, 512);
    check("never_charged", pot, 16'hffff);

    run_period(1, 100, 37, NEVER, 512);
    check("mid_s1", pot, {8'd37, 8'd100});

    run_period(1, -300, -300, NEVER, 512);
    check("precharged", pot, 16'd0);
    run_period(1, -300, -300, 300, 512);
    check("precharged_drop", pot, 16'd0);

    run_period(1, 255, 0, NEVER, 512);
    check("edge_255_0", pot, {8'd0, 8'd255});

    run_period(1, 50, 60, NEVER, 401);
    apply_reset(1);
    check("midreset_xy", pot, 16'd0);
    check("midreset_disc", 16'(pot_o.discharge), 16'd1);
    run_period(1, 999, 999, NEVER, 512);
    check("after_midreset", pot, 16'hffff);

    run_period(7, 100, 37, NEVER, 512);
    check("mid_s7", pot, {8'd37, 8'd100});
    run_period(3, 100, 37, NEVER, 512);
    check("mid_s3", pot, {8'd37, 8'd100});

    for (int r = 0; r < 8; r++) begin
      int s, kx, ky, d0;
      s  = $urandom_range(1, 4);
      kx = int'($urandom_range(0, 290)) - 20;
      ky = int'($urandom_range(0, 290)) - 20;
      d0 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(256, 600)) : NEVER;
      run_period(s, kx, ky, d0, 512);
    end

    repeat (3) @(posedge clk);
    #2;
    check("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
